// File: rtl/fft_iter_addr_gen_pkg.sv
// Shared definitions for the iterative FFT address sequencer.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package fft_iter_addr_gen_pkg;

    // Sequencer states: idle, issuing reads for one stage, waiting for that stage's writes to land.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;

    // Read-to-write latency: RAM read latency followed by butterfly latency.
    function automatic int pipe_lat(input int ram_lat, input int bf_lat);
        return ram_lat + bf_lat;
    endfunction

    // Ping-pong convention: even stages read bank 0, odd stages read bank 1.
    function automatic logic rd_bank_sel(input logic stage_lsb);
        return stage_lsb;
    endfunction

    // Results always go to the bank not being read.
    function automatic logic wr_bank_sel(input logic stage_lsb);
        return ~stage_lsb;
    endfunction

endpackage

// File: rtl/fft_iter_addr_gen_if.sv
// Control/address bundle between the FFT sequencer and the RAM/butterfly datapath.
// Latency: n/a (wiring only).
// Backpressure: none; the datapath is assumed to always accept the schedule.
interface fft_iter_addr_gen_if #(
    parameter int AWL = 8
);
    localparam int SWL = $clog2(AWL);

    logic             i_START;
    logic             o_BUSY;
    logic             o_DONE;
    logic [SWL-1:0]   o_STAGE;
    logic             o_RD_EN;
    logic             o_RD_BANK;
    logic [AWL-1:0]   o_RD_ADDR_A;
    logic [AWL-1:0]   o_RD_ADDR_B;
    logic [AWL-2:0]   o_TW_ADDR;
    logic             o_BF_VALID;
    logic             o_WR_EN;
    logic             o_WR_BANK;
    logic [AWL-1:0]   o_WR_ADDR_A;
    logic [AWL-1:0]   o_WR_ADDR_B;

    modport master (
        input  i_START,
        output o_BUSY, o_DONE, o_STAGE, o_RD_EN, o_RD_BANK, o_RD_ADDR_A, o_RD_ADDR_B,
               o_TW_ADDR, o_BF_VALID, o_WR_EN, o_WR_BANK, o_WR_ADDR_A, o_WR_ADDR_B
    );

    modport slave (
        output i_START,
        input  o_BUSY, o_DONE, o_STAGE, o_RD_EN, o_RD_BANK, o_RD_ADDR_A, o_RD_ADDR_B,
               o_TW_ADDR, o_BF_VALID, o_WR_EN, o_WR_BANK, o_WR_ADDR_A, o_WR_ADDR_B
    );
endinterface

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register that carries control/address words alongside the datapath.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; shifts every cycle, RST empties every slot.
module fft_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    // Shift one slot per cycle; reset flushes everything so no stale write escapes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_iter_addr_gen.sv
// Read/twiddle/write address sequencer for an in-place iterative radix-2 DIT FFT.
// Latency: first read 1 cycle after START; writes trail reads by RAM_LAT+BF_LAT.
// Backpressure: none; START is ignored unless idle, one butterfly is issued every READ cycle.
module fft_iter_addr_gen
    import fft_iter_addr_gen_pkg::*;
#(
    parameter int AWL     = 8,
    parameter int RAM_LAT = 1,
    parameter int BF_LAT  = 4
) (
    input  logic                CLK,
    input  logic                RST,
    fft_iter_addr_gen_if.master bus
);

    localparam int L   = pipe_lat(RAM_LAT, BF_LAT);
    localparam int SWL = $clog2(AWL);
    localparam int KW  = AWL - 1;
    localparam int DW  = $clog2(L);
    localparam int WRW = 2 + 2 * AWL;

    localparam logic [KW-1:0]  K_LAST = '1;
    localparam logic [DW-1:0]  D_LAST = DW'(L - 1);
    localparam logic [SWL-1:0] S_LAST = SWL'(AWL - 1);
    localparam logic [AWL-1:0] ONE    = AWL'(1);

    fsm_state_t      state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SWL-1:0]  stage_q, stage_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            done_q, done_d;

    logic            rd_en;
    logic [AWL-1:0]  k_ext, span_bit, span_mask, addr_a, addr_b;
    logic [SWL-1:0]  tw_shift;
    logic [KW-1:0]   tw_idx;
    logic [WRW-1:0]  wr_in, wr_out;
    logic [0:0]      bf_vld;

    // Sequencer state and counters; reset returns everything to an idle, cleared schedule.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    // Next-state: N/2 butterflies per stage, then L idle cycles so the last write lands first.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                k_d     = '0;
                stage_d = '0;
                drain_d = '0;
                if (bus.i_START) state_d = ST_READ;
            end
            ST_READ: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == D_LAST) begin
                    drain_d = '0;
                    if (stage_q == S_LAST) begin
                        stage_d = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stage_d = stage_q + 1'b1;
                        state_d = ST_READ;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_en = (state_q == ST_READ);

    // Operand pair = k with a zero inserted at bit 'stage' (A) or a one there (B); idle buses read 0.
    always_comb begin
        k_ext     = {1'b0, k_q};
        span_bit  = ONE << stage_q;
        span_mask = span_bit - ONE;
        addr_a    = ((k_ext & ~span_mask) << 1) | (k_ext & span_mask);
        addr_b    = addr_a | span_bit;
        tw_shift  = S_LAST - stage_q;
        tw_idx    = KW'((k_ext & span_mask) << tw_shift);
        if (!rd_en) begin
            addr_a = '0;
            addr_b = '0;
            tw_idx = '0;
        end
    end

    assign wr_in = {rd_en, rd_en & wr_bank_sel(stage_q[0]), addr_a, addr_b};

    fft_delay_line #(.WIDTH(WRW), .DEPTH(L)) u_wr_dly (
        .CLK  (CLK),
        .RST  (RST),
        .din  (wr_in),
        .dout (wr_out)
    );

    fft_delay_line #(.WIDTH(1), .DEPTH(RAM_LAT)) u_bf_dly (
        .CLK  (CLK),
        .RST  (RST),
        .din  (rd_en),
        .dout (bf_vld)
    );

    assign bus.o_BUSY      = (state_q != ST_IDLE);
    assign bus.o_DONE      = done_q;
    assign bus.o_STAGE     = stage_q;
    assign bus.o_RD_EN     = rd_en;
    assign bus.o_RD_BANK   = rd_bank_sel(stage_q[0]);
    assign bus.o_RD_ADDR_A = addr_a;
    assign bus.o_RD_ADDR_B = addr_b;
    assign bus.o_TW_ADDR   = tw_idx;
    assign bus.o_BF_VALID  = bf_vld[0];
    assign bus.o_WR_EN     = wr_out[WRW-1];
    assign bus.o_WR_BANK   = wr_out[WRW-2];
    assign bus.o_WR_ADDR_A = wr_out[2*AWL-1:AWL];
    assign bus.o_WR_ADDR_B = wr_out[AWL-1:0];

endmodule
